// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receiver and transmitter.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;
    localparam int BAUD_CNT_W = 12;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-period start delay, sticky
// framing/overrun flags and a set-wins ready flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam logic [1:0] IDLE  = 2'(RX_IDLE);
    localparam logic [1:0] START = 2'(RX_START);
    localparam logic [1:0] DATA  = 2'(RX_DATA);
    localparam logic [1:0] STOP  = 2'(RX_STOP);

    localparam logic [BAUD_CNT_W-1:0] FULL_PERIOD = BAUD_CNT_W'(BAUD_DIV);
    localparam logic [BAUD_CNT_W-1:0] HALF_PERIOD = BAUD_CNT_W'(BAUD_DIV / 2);

    logic                  rx_s;
    logic                  rx_prev;
    logic                  fall;
    logic [1:0]            state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic                  strobe;
    logic [3:0]            bit_cnt;
    logic [8:0]            shift;

    rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line   (RX),
        .synced (rx_s)
    );

    assign fall = rx_prev & ~rx_s;

    // The strobe fires on the clock where the down-count reaches zero; that clock
    // reloads instead, so each sample is exactly one load value after the last.
    assign strobe = (state != IDLE) && (baud_cnt == BAUD_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev  <= 1'b1;
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            rx_prev <= rx_s;

            // Clears first; a flag set later in this block overrides them.
            if (clr_rdy) begin
                rdy <= 1'b0;
            end
            if (clr_err) begin
                frm_err <= 1'b0;
                ovr_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        baud_cnt <= HALF_PERIOD;
                    end
                end
                START: begin
                    if (strobe) begin
                        if (!rx_s) begin
                            state    <= DATA;
                            bit_cnt  <= '0;
                            baud_cnt <= FULL_PERIOD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (strobe) begin
                        shift    <= {shift[8], rx_s, shift[7:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        baud_cnt <= FULL_PERIOD;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_CNT_W'(1);
                    end
                end
                STOP: begin
                    if (strobe) begin
                        shift[8] <= rx_s;
                        state    <= IDLE;
                        if (rx_s) begin
                            rx_data <= shift[7:0];
                            rdy     <= 1'b1;
                            if (rdy) begin
                                ovr_err <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance at the default divider, one fast instance.
module tb_uart_rx;

    localparam int BB = 2604;
    localparam int BF = 32;
    // Cycles from driving the start bit to rdy visible: 2 synchronizer flops + edge-to-rdy interval.
    localparam int DONE_B = 2 + BB / 2 + 9 * BB + 1;
    localparam int DONE_F = 2 + BF / 2 + 9 * BF + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_b, rx_b, clr_rdy_b, clr_err_b;
    logic [7:0] data_b;
    logic       rdy_b, frm_b, ovr_b;
    logic       rst_n_f, rx_f, clr_rdy_f, clr_err_f;
    logic [7:0] data_f;
    logic       rdy_f, frm_f, ovr_f;

    uart_rx #(.BAUD_DIV(BB)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .RX(rx_b), .clr_rdy(clr_rdy_b), .clr_err(clr_err_b),
        .rx_data(data_b), .rdy(rdy_b), .frm_err(frm_b), .ovr_err(ovr_b)
    );

    uart_rx #(.BAUD_DIV(BF)) dut_f (
        .clk(clk), .rst_n(rst_n_f), .RX(rx_f), .clr_rdy(clr_rdy_f), .clr_err(clr_err_f),
        .rx_data(data_f), .rdy(rdy_f), .frm_err(frm_f), .ovr_err(ovr_f)
    );

    int checks = 0;
    int failures = 0;

    // Reference model of the fast instance's visible outputs.
    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr;

    function automatic void model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            m_ovr  = m_ovr | m_rdy;
            m_data = b;
            m_rdy  = 1'b1;
        end else begin
            m_frm = 1'b1;
        end
    endfunction

    // Drives one frame on the fast instance; leaves the line at the stop-bit level.
    task automatic drive_frame_f(input logic [7:0] b, input logic stop,
                                 input int clr_at, input int rst_at);
        for (int k = 1; k <= 10 * BF; k++) begin
            int idx;
            @(negedge clk);
            idx = (k - 1) / BF;
            if (idx == 0) rx_f = 1'b0;
            else if (idx <= 8) rx_f = b[idx-1];
            else rx_f = stop;
            clr_rdy_f = (k == clr_at);
            if (rst_at != 0 && k >= rst_at && k < rst_at + 2) begin
                rst_n_f = 1'b0;
            end else if (rst_at != 0 && k == rst_at + 2) begin
                rst_n_f = 1'b1;
                rx_f    = 1'b1;
                return;
            end
        end
        @(negedge clk);
        clr_rdy_f = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (data_b !== 8'h00 || rdy_b !== 1'b0 || frm_b !== 1'b0 || ovr_b !== 1'b0) begin
            failures++; $display("FAIL reset_big got data=%h rdy=%b frm=%b ovr=%b exp 00 0 0 0", data_b, rdy_b, frm_b, ovr_b);
        end
        checks++; if (data_f !== 8'h00 || rdy_f !== 1'b0 || frm_f !== 1'b0 || ovr_f !== 1'b0) begin
            failures++; $display("FAIL reset_fast got data=%h rdy=%b frm=%b ovr=%b exp 00 0 0 0", data_f, rdy_f, frm_f, ovr_f);
        end
    endtask

    task automatic test_default_frame();
        logic [7:0] b;
        b = 8'hA5;
        for (int k = 1; k <= 10 * BB; k++) begin
            int idx;
            @(negedge clk);
            if (k == DONE_B) begin
                checks++; if (rdy_b !== 1'b0) begin
                    failures++; $display("FAIL a5_rdy_early got=%b exp=0", rdy_b);
                end
            end
            if (k == DONE_B + 1) begin
                checks++; if (rdy_b !== 1'b1) begin
                    failures++; $display("FAIL a5_rdy_ontime got=%b exp=1", rdy_b);
                end
            end
            idx = (k - 1) / BB;
            if (idx == 0) rx_b = 1'b0;
            else if (idx <= 8) rx_b = b[idx-1];
            else rx_b = 1'b1;
        end
        @(negedge clk);
        checks++; if (data_b !== 8'hA5 || frm_b !== 1'b0) begin
            failures++; $display("FAIL a5_data got data=%h frm=%b exp A5 0", data_b, frm_b);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk); clr_rdy_b = 1'b1;
        @(negedge clk); clr_rdy_b = 1'b0;
        rx_b = 1'b0;
        repeat (1000) @(negedge clk);
        rx_b = 1'b1;
        repeat (3000) @(negedge clk);
        checks++; if (rdy_b !== 1'b0 || frm_b !== 1'b0 || ovr_b !== 1'b0 || data_b !== 8'hA5) begin
            failures++; $display("FAIL glitch got rdy=%b frm=%b ovr=%b data=%h exp 0 0 0 A5", rdy_b, frm_b, ovr_b, data_b);
        end
    endtask

    task automatic test_back_to_back();
        drive_frame_f(8'h00, 1'b1, 0, 0);
        model_frame(8'h00, 1'b1);
        drive_frame_f(8'hFF, 1'b1, 0, 0);
        model_frame(8'hFF, 1'b1);
        checks++; if (data_f !== m_data || rdy_f !== m_rdy || ovr_f !== m_ovr) begin
            failures++; $display("FAIL b2b got data=%h rdy=%b ovr=%b exp %h %b %b", data_f, rdy_f, ovr_f, m_data, m_rdy, m_ovr);
        end
    endtask

    task automatic test_framing();
        @(negedge clk); clr_rdy_f = 1'b1; clr_err_f = 1'b1;
        @(negedge clk); clr_rdy_f = 1'b0; clr_err_f = 1'b0;
        m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        checks++; if (rdy_f !== 1'b0 || ovr_f !== 1'b0) begin
            failures++; $display("FAIL clear_all got rdy=%b ovr=%b exp 0 0", rdy_f, ovr_f);
        end
        drive_frame_f(8'h3C, 1'b0, 0, 0);
        model_frame(8'h3C, 1'b0);
        checks++; if (frm_f !== 1'b1 || rdy_f !== 1'b0 || data_f !== m_data) begin
            failures++; $display("FAIL frame_err got frm=%b rdy=%b data=%h exp 1 0 %h", frm_f, rdy_f, data_f, m_data);
        end
        repeat (4 * BF) @(negedge clk);
        checks++; if (rdy_f !== 1'b0 || data_f !== m_data) begin
            failures++; $display("FAIL break_hold got rdy=%b data=%h exp 0 %h", rdy_f, data_f, m_data);
        end
        rx_f = 1'b1;
        repeat (10) @(negedge clk);
        clr_err_f = 1'b1;
        @(negedge clk); clr_err_f = 1'b0;
        m_frm = 1'b0;
        checks++; if (frm_f !== 1'b0) begin
            failures++; $display("FAIL clr_err got frm=%b exp=0", frm_f);
        end
    endtask

    task automatic test_reset_mid();
        drive_frame_f(8'h77, 1'b1, 0, 5 * BF + BF / 2);
        model_reset();
        @(negedge clk);
        checks++; if (data_f !== 8'h00 || rdy_f !== 1'b0 || frm_f !== 1'b0 || ovr_f !== 1'b0) begin
            failures++; $display("FAIL reset_mid got data=%h rdy=%b frm=%b ovr=%b exp 00 0 0 0", data_f, rdy_f, frm_f, ovr_f);
        end
        drive_frame_f(8'h5A, 1'b1, 0, 0);
        model_frame(8'h5A, 1'b1);
        checks++; if (data_f !== m_data || rdy_f !== m_rdy || frm_f !== m_frm) begin
            failures++; $display("FAIL after_reset got data=%h rdy=%b frm=%b exp %h %b %b", data_f, rdy_f, frm_f, m_data, m_rdy, m_frm);
        end
    endtask

    task automatic test_clr_collision();
        logic [7:0] b;
        b = 8'($urandom);
        drive_frame_f(b, 1'b1, 0, 0);
        model_frame(b, 1'b1);
        drive_frame_f(8'h81, 1'b1, DONE_F, 0);
        model_frame(8'h81, 1'b1);
        checks++; if (rdy_f !== 1'b1 || data_f !== 8'h81 || ovr_f !== m_ovr) begin
            failures++; $display("FAIL clr_collide got rdy=%b data=%h ovr=%b exp 1 81 %b", rdy_f, data_f, ovr_f, m_ovr);
        end
        @(negedge clk); clr_rdy_f = 1'b1;
        @(negedge clk); clr_rdy_f = 1'b0;
        m_rdy = 1'b0;
        checks++; if (rdy_f !== 1'b0 || data_f !== 8'h81) begin
            failures++; $display("FAIL clr_rdy got rdy=%b data=%h exp 0 81", rdy_f, data_f);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            drive_frame_f(b, stop, 0, 0);
            model_frame(b, stop);
            checks++; if (data_f !== m_data || rdy_f !== m_rdy || frm_f !== m_frm || ovr_f !== m_ovr) begin
                failures++; $display("FAIL rand_frame%0d got %h %b %b %b exp %h %b %b %b", i,
                                     data_f, rdy_f, frm_f, ovr_f, m_data, m_rdy, m_frm, m_ovr);
            end
            rx_f = 1'b1;
            @(negedge clk);
            clr_rdy_f = ($urandom_range(0, 1) == 1);
            clr_err_f = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (clr_rdy_f) m_rdy = 1'b0;
            if (clr_err_f) begin m_frm = 1'b0; m_ovr = 1'b0; end
            clr_rdy_f = 1'b0;
            clr_err_f = 1'b0;
            checks++; if (rdy_f !== m_rdy || frm_f !== m_frm || ovr_f !== m_ovr) begin
                failures++; $display("FAIL rand_clear%0d got %b %b %b exp %b %b %b", i,
                                     rdy_f, frm_f, ovr_f, m_rdy, m_frm, m_ovr);
            end
            repeat ($urandom_range(3, 8)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n_b = 1'b0; rx_b = 1'b1; clr_rdy_b = 1'b0; clr_err_b = 1'b0;
        rst_n_f = 1'b0; rx_f = 1'b1; clr_rdy_f = 1'b0; clr_err_f = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n_b = 1'b1;
        rst_n_f = 1'b1;
        repeat (4) @(negedge clk);
        test_default_frame();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        test_clr_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per bit period; it SHALL be even and at least 16.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port RX  input  1  asynchronous serial line, idle high, 8N1 frames sent LSB first.
REQ-005 SHALL have port clr_rdy  input  1  consumer acknowledge that clears rdy.
REQ-006 SHALL have port clr_err  input  1  clears frm_err and ovr_err.
REQ-007 SHALL have port rx_data  output  8  last correctly framed byte, held stable until the next good frame.
REQ-008 SHALL have port rdy  output  1  set/reset flop, high while rx_data holds an unacknowledged byte.
REQ-009 SHALL have port frm_err  output  1  sticky flag: stop bit sampled low.
REQ-010 SHALL have port ovr_err  output  1  sticky flag: good frame completed while rdy was already high.

Function
REQ-011 SHALL pass RX through a two-flop synchronizer, plus a third flop for edge detection, before any use; no logic SHALL read raw RX.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP.
REQ-013 IDLE SHALL move to START on a synchronized falling edge (previous 1, current 0) and load the baud counter with BAUD_DIV/2.
REQ-014 The baud counter SHALL be 12 bits wide, count down once per clock in START, DATA and STOP, and produce a one-cycle sample strobe when it reaches 0.
REQ-015 On the strobe in START: if the synchronized RX is 0, the block SHALL go to DATA, clear bit_cnt and reload BAUD_DIV; if RX is 1 (glitch or false start), it SHALL return to IDLE with no flag change.
REQ-016 On each strobe in DATA, the block SHALL shift the synchronized RX into bit 7 of a 9-bit shift register (right shift), increment the 4-bit bit_cnt and reload BAUD_DIV; after the 8th sample it SHALL go to STOP.
REQ-017 On the strobe in STOP with RX=1, the block SHALL load rx_data from the shift register, set rdy, and return to IDLE.
REQ-018 On the strobe in STOP with RX=0, the block SHALL set frm_err, leave rx_data and rdy unchanged, and return to IDLE; a held-low line (break) SHALL produce no further frames until RX returns high and falls again.
REQ-019 If a good frame completes while rdy=1, the block SHALL set ovr_err and overwrite rx_data with the new byte, and rdy SHALL stay 1.
REQ-020 When clr_rdy and a good-frame set occur in the same cycle, set SHALL win (rdy=1); the same set-wins rule SHALL apply to clr_err against frm_err or ovr_err.
REQ-021 clr_rdy and clr_err SHALL take effect on the next edge; asserting them while the block is idle SHALL be harmless.
REQ-022 The interval from the synchronized falling edge to the rdy rising edge SHALL be exactly BAUD_DIV/2 + 9*BAUD_DIV + 1 clocks (24739 at the default).

Reset
REQ-023 While rst_n=0 at posedge clk, the block SHALL put state=IDLE, all synchronizer flops=1, baud counter=0, bit_cnt=0, shift register=0, rx_data=8'h00, rdy=0, frm_err=0 and ovr_err=0.
REQ-024 A reset mid-frame SHALL abandon the frame with no output change other than the reset values; the first falling edge after release SHALL start a new frame.

Structure
REQ-025 A shared package uart_pkg SHALL hold the BAUD_DIV default constant and the rx state enum typedef, shared with the transmitter.
REQ-026 The two-flop synchronizer SHALL be a sub-module named rx_sync (parameter reset value 1); all other logic SHALL be flat in uart_rx.

Verification
REQ-027 Frame 0xA5 at BAUD_DIV=2604 -> rx_data=8'hA5 and rdy rising 24739 clocks after the synchronized edge, with frm_err=0.
REQ-028 Back-to-back frames 0x00 then 0xFF with no clr_rdy -> rx_data=8'hFF, rdy=1, ovr_err=1.
REQ-029 Frame 0x3C with the stop bit driven 0 -> frm_err=1, rdy=0, rx_data unchanged; then clr_err -> frm_err=0 on the next cycle.
REQ-030 A 1000-clock low glitch on an idle RX -> return to IDLE after the START sample; rdy, frm_err and ovr_err all stay 0.
REQ-031 rst_n pulsed low during DATA bit 4 -> all outputs at reset values; a following frame 0x5A is received correctly.
REQ-032 clr_rdy asserted on the same cycle a good frame 0x81 completes -> rdy=1 and rx_data=8'h81.
